mp_shared_cache: RTL and testbench

//  Shared direct-mapped data cache with a parametrised number of CPU ports, replacing the fixed two-port cache.
//  A round-robin arbiter grants one request at a time.

---
 rtl/mp_shared_cache_if.sv | 30 +++
 rtl/mp_shared_cache.sv | 160 ++++++++++++++++
 tb/tb_mp_shared_cache.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_shared_cache_if.sv
// CPU <-> shared cache bus: per-CPU request lanes in, one broadcast response out.
interface mp_shared_cache_if #(
  parameter int NUM_CPUS = 2,
  parameter int TAG_W    = 11,
  parameter int OFF_W    = 1,
  parameter int DATA_W   = 8
);
  localparam int ID_W  = $clog2(NUM_CPUS);
  localparam int REQ_W = 1 + TAG_W + OFF_W + DATA_W;
  localparam int RSP_W = ID_W + REQ_W;

  logic [NUM_CPUS-1:0]       req_valid;
  logic [NUM_CPUS*REQ_W-1:0] req_bus;
  logic [NUM_CPUS-1:0]       grant;
  logic                      is_busy;
  logic                      resp_valid;
  logic [RSP_W-1:0]          resp_bus;
  logic [15:0]               hit_count;
  logic [15:0]               miss_count;

  modport master (
    output req_valid, req_bus,
    input  grant, is_busy, resp_valid, resp_bus, hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_bus,
    output grant, is_busy, resp_valid, resp_bus, hit_count, miss_count
  );
endinterface

// File: rtl/mp_shared_cache.sv
// Shared direct-mapped write-through cache, round-robin arbitration across
// NUM_CPUS ports, one transaction in flight, broadcast response.
module mp_shared_cache #(
  parameter int NUM_CPUS = 2,
  parameter int TAG_W    = 11,
  parameter int OFF_W    = 1,
  parameter int DATA_W   = 8,
  parameter int IDX_W    = 4,
  parameter int MISS_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  mp_shared_cache_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_CPUS);
  localparam int LINES = 2 ** IDX_W;
  localparam int WORDS = 2 ** OFF_W;
  localparam int MEM_D = 2 ** (TAG_W + OFF_W);
  localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

  typedef struct packed {
    logic              st;
    logic [TAG_W-1:0]  tag;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    req_t            req;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT, RESPOND} state_t;

  state_t            state;
  req_t              cur;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [LINES-1:0]  line_vld;
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [DATA_W-1:0] line_data [LINES][WORDS];
  logic [DATA_W-1:0] mem       [MEM_D];

  req_t [NUM_CPUS-1:0] reqs;
  assign reqs = bus.req_bus;

  logic [IDX_W-1:0]          idx;
  logic                      hit;
  logic                      fill_now;
  logic [TAG_W+OFF_W-1:0]    addr;
  assign idx      = cur.tag[IDX_W-1:0];
  assign hit      = line_vld[idx] && (line_tag[idx] == cur.tag);
  assign fill_now = (state == MISS_WAIT) && (cnt == '0);
  assign addr     = {cur.tag, cur.off};

  // Round-robin pick: first requester after the last winner, wrapping.
  logic            win_found;
  logic [ID_W-1:0] win_id;
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_CPUS; k++) begin
      if (!win_found && bus.req_valid[ID_W'((int'(rr_ptr) + k) % NUM_CPUS)]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(rr_ptr) + k) % NUM_CPUS);
      end
    end
  end

  // Response word: stored data, refilled word, or cached word on a hit.
  logic [DATA_W-1:0] rsp_word;
  rsp_t              rsp_next;
  always_comb begin
    if (cur.st)                  rsp_word = cur.data;
    else if (state == MISS_WAIT) rsp_word = mem[addr];
    else                         rsp_word = line_data[idx][cur.off];
    rsp_next          = '0;
    rsp_next.id       = cur_id;
    rsp_next.req      = cur;
    rsp_next.req.data = rsp_word;
  end

  // Transaction FSM with registered grant/busy/response/counter outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cur            <= '0;
      cur_id         <= '0;
      rr_ptr         <= ID_W'(NUM_CPUS - 1);
      cnt            <= '0;
      line_vld       <= '0;
      bus.grant      <= '0;
      bus.is_busy    <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_bus   <= '0;
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else begin
      bus.grant      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_bus   <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cur         <= reqs[win_id];
            cur_id      <= win_id;
            rr_ptr      <= win_id;
            bus.grant   <= NUM_CPUS'(1) << win_id;
            bus.is_busy <= 1'b1;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (cur.st || hit) begin
            if (!cur.st && bus.hit_count != 16'hFFFF)
              bus.hit_count <= bus.hit_count + 16'd1;
            bus.resp_valid <= 1'b1;
            bus.resp_bus   <= rsp_next;
            state          <= RESPOND;
          end else begin
            if (bus.miss_count != 16'hFFFF)
              bus.miss_count <= bus.miss_count + 16'd1;
            cnt   <= CNT_W'(MISS_LAT - 1);
            state <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (fill_now) begin
            line_vld[idx]  <= 1'b1;
            bus.resp_valid <= 1'b1;
            bus.resp_bus   <= rsp_next;
            state          <= RESPOND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          bus.is_busy <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Line tags/data and backing store carry no reset; a reset edge suppresses writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOOKUP && cur.st) begin
        mem[addr] <= cur.data;
        if (hit) line_data[idx][cur.off] <= cur.data;
      end
      if (fill_now) begin
        line_tag[idx] <= cur.tag;
        for (int w = 0; w < WORDS; w++)
          line_data[idx][OFF_W'(w)] <= mem[{cur.tag, OFF_W'(w)}];
      end
    end
  end
endmodule

// File: tb/tb_mp_shared_cache.sv
// Directed + randomized bench for mp_shared_cache against a behavioural model.
module tb_mp_shared_cache;
  localparam int TAG_W    = 11;
  localparam int OFF_W    = 1;
  localparam int DATA_W   = 8;
  localparam int MISS_LAT = 4;
  localparam int REQ_W    = 1 + TAG_W + OFF_W + DATA_W;
  localparam int RSP4_W   = 2 + REQ_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mp_shared_cache_if #(.NUM_CPUS(2)) bus2 ();
  mp_shared_cache_if #(.NUM_CPUS(4)) bus4 ();

  mp_shared_cache #(.NUM_CPUS(2), .MISS_LAT(MISS_LAT)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mp_shared_cache #(.NUM_CPUS(4), .MISS_LAT(MISS_LAT)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int checks = 0;
  int errors = 0;

  // Reference model: write-through means a valid line always mirrors memory,
  // so a load returns the memory word; only hit/miss needs line bookkeeping.
  logic [7:0]  mem_m [int];
  bit          vld_m [16];
  logic [10:0] tag_m [16];
  int          hits_m, miss_m, rr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (vld_m[i]) vld_m[i] = 1'b0;
    hits_m = 0;
    miss_m = 0;
    rr_m   = 1;
  endtask

  task automatic model_acc(input bit st, input logic [10:0] tag, input logic off,
                           input logic [7:0] d, output logic [7:0] rd, output int lat);
    int idx, a;
    idx = int'(tag) % 16;
    a   = int'(tag) * 2 + int'(off);
    if (st) begin
      mem_m[a] = d;
      rd  = d;
      lat = 2;
    end else begin
      if (vld_m[idx] && tag_m[idx] == tag) begin
        if (hits_m < 65535) hits_m++;
        lat = 2;
      end else begin
        if (miss_m < 65535) miss_m++;
        vld_m[idx] = 1'b1;
        tag_m[idx] = tag;
        lat = 2 + MISS_LAT;
      end
      rd = mem_m.exists(a) ? mem_m[a] : 8'h00;
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [3:0] mask, input int n);
    for (int k = 1; k <= n; k++)
      if (mask[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  // One transaction on the 2-CPU cache: request, grant, response, counters.
  task automatic do_req(input int cpu, input bit st, input logic [10:0] tag,
                        input logic off, input logic [7:0] d);
    logic [7:0] rd;
    int lat, n;
    bit got;
    bus2.req_bus[cpu*REQ_W +: REQ_W] = {st, tag, off, d};
    bus2.req_valid[cpu] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (bus2.grant != '0);
    end
    chk("grant", 64'(bus2.grant), 64'(1) << cpu);
    bus2.req_valid[cpu] = 1'b0;
    rr_m = cpu;
    model_acc(st, tag, off, d, rd, lat);
    n = 1;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      got = bus2.resp_valid;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("resp_bus", 64'(bus2.resp_bus), 64'({cpu[0], st, tag, off, rd}));
    chk("hit_count", 64'(bus2.hit_count), 64'(hits_m));
    chk("miss_count", 64'(bus2.miss_count), 64'(miss_m));
  endtask

  int ng, nr, gap, expi, last, raised_at;
  bit seen_resp, got, any_resp, cpu2_served;
  logic [63:0] exp_rsp;
  logic [7:0]  rd;
  int          lat;

  initial begin
    reset = 1'b1;
    bus2.req_valid = '0;
    bus2.req_bus   = '0;
    bus4.req_valid = '0;
    bus4.req_bus   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(bus2.grant), 0);
    chk("rst_busy", 64'(bus2.is_busy), 0);
    chk("rst_resp_valid", 64'(bus2.resp_valid), 0);
    chk("rst_resp_bus", 64'(bus2.resp_bus), 0);
    chk("rst_hits", 64'(bus2.hit_count), 0);
    chk("rst_misses", 64'(bus2.miss_count), 0);
    reset = 1'b0;

    // 1-2: cold load miss, store from CPU1, then load hit from CPU0.
    do_req(0, 1'b0, 11'h050, 1'b1, 8'h00);
    do_req(1, 1'b1, 11'h050, 1'b1, 8'hFF);
    do_req(0, 1'b0, 11'h050, 1'b1, 8'h00);

    // 4: index-0 conflicts, store miss to an evicted tag, refill sees it.
    do_req(0, 1'b0, 11'h010, 1'b0, 8'h00);
    do_req(1, 1'b0, 11'h020, 1'b0, 8'h00);
    do_req(1, 1'b1, 11'h010, 1'b0, 8'h5A);
    do_req(0, 1'b0, 11'h010, 1'b0, 8'h00);

    // 3: both CPUs hold requests for three transactions from a fresh reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    bus2.req_bus[0 +: REQ_W]     = {1'b0, 11'h050, 1'b1, 8'h00};
    bus2.req_bus[REQ_W +: REQ_W] = {1'b0, 11'h061, 1'b0, 8'h00};
    bus2.req_valid = 2'b11;
    ng = 0; nr = 0; gap = 0; seen_resp = 1'b0; exp_rsp = '0;
    for (int c = 0; c < 200 && nr < 3; c++) begin
      @(negedge clk);
      if (seen_resp && !bus2.is_busy) gap++;
      if (bus2.grant != '0) begin
        expi = rr_pick(rr_m, {2'b00, bus2.req_valid}, 2);
        chk("t3_grant_order", 64'(bus2.grant), 64'(1) << expi);
        if (ng > 0) chk("t3_idle_gap", 64'(gap), 1);
        rr_m = expi;
        model_acc(1'b0, expi == 0 ? 11'h050 : 11'h061, expi == 0 ? 1'b1 : 1'b0, 8'h00, rd, lat);
        exp_rsp = 64'({expi[0], 1'b0, expi == 0 ? 11'h050 : 11'h061, expi == 0 ? 1'b1 : 1'b0, rd});
        ng++;
        gap = 0;
        seen_resp = 1'b0;
        if (ng == 3) bus2.req_valid = '0;
      end
      if (bus2.resp_valid) begin
        chk("t3_resp", 64'(bus2.resp_bus), exp_rsp);
        seen_resp = 1'b1;
        nr++;
      end
    end
    chk("t3_responses", 64'(nr), 3);
    chk("t3_misses", 64'(bus2.miss_count), 64'(miss_m));
    @(negedge clk);

    // 5: reset during MISS_WAIT drops the fill and the counters.
    bus2.req_bus[0 +: REQ_W] = {1'b0, 11'h033, 1'b0, 8'h00};
    bus2.req_valid[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (bus2.grant != '0);
    end
    chk("t5_grant", 64'(bus2.grant), 1);
    bus2.req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_in_miss_busy", 64'(bus2.is_busy), 1);
    chk("t5_in_miss_no_resp", 64'(bus2.resp_valid), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("t5_busy", 64'(bus2.is_busy), 0);
    chk("t5_resp_valid", 64'(bus2.resp_valid), 0);
    chk("t5_misses", 64'(bus2.miss_count), 0);
    chk("t5_hits", 64'(bus2.hit_count), 0);
    any_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_resp |= bus2.resp_valid;
    end
    chk("t5_no_late_resp", 64'(any_resp), 0);
    do_req(0, 1'b0, 11'h033, 1'b0, 8'h00);

    // Reset on the store's write edge: the store must not reach memory.
    bus2.req_bus[REQ_W +: REQ_W] = {1'b1, 11'h044, 1'b0, 8'hA5};
    bus2.req_valid[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (bus2.grant != '0);
    end
    chk("rst_store_grant", 64'(bus2.grant), 2);
    bus2.req_valid[1] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_store_grant_clr", 64'(bus2.grant), 0);
    chk("rst_store_resp_clr", 64'(bus2.resp_valid), 0);
    do_req(0, 1'b0, 11'h044, 1'b0, 8'h00);

    // Randomized traffic over a small tag pool to force hits and conflicts.
    for (int t = 0; t < 40; t++) begin
      do_req($urandom_range(0, 1), 1'($urandom_range(0, 1)),
             11'(($urandom_range(0, 2) << 4) | $urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 8'($urandom));
    end

    // 6: 4-CPU cache, CPUs 1 and 3 continuous, CPU2 joins mid-sequence.
    for (int i = 0; i < 4; i++) bus4.req_bus[i*REQ_W +: REQ_W] = {1'b0, 11'(i), 1'b0, 8'h00};
    bus4.req_valid = 4'b1010;
    ng = 0; raised_at = 0; last = -1; expi = 3; cpu2_served = 1'b0;
    for (int c = 0; c < 400 && ng < 6; c++) begin
      @(negedge clk);
      if (bus4.resp_valid) chk("t6_resp_id", 64'(bus4.resp_bus[RSP4_W-1 -: 2]), 64'(last));
      if (bus4.grant != '0) begin
        expi = rr_pick(last < 0 ? 3 : last, bus4.req_valid, 4);
        chk("t6_grant", 64'(bus4.grant), 64'(1) << expi);
        last = expi;
        ng++;
        if (ng == 2) begin
          bus4.req_valid[2] = 1'b1;
          raised_at = ng;
        end else if (expi == 2) begin
          chk("t6_cpu2_wait", 64'((ng - raised_at) <= 2), 1);
          cpu2_served = 1'b1;
          bus4.req_valid[2] = 1'b0;
        end
      end
    end
    bus4.req_valid = '0;
    chk("t6_grants", 64'(ng), 6);
    chk("t6_cpu2_served", 64'(cpu2_served), 1);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
